// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary conversion helpers for the dual-clock FIFO.
// Both clock domains use the same helpers so their pointer encodings always agree.
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE  = 3;
    localparam int FIFO_DATA_WIDTH = 8;

    // Helpers work on a fixed wide vector. Callers zero-extend narrower
    // pointers and truncate the result; zero upper bits stay zero through
    // both conversions, so the result is correct for any width up to FN_W.
    localparam int FN_W = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b[FN_W-1] = g[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
// The same block serves the write side, where it carries the read pointer.
module fifo_ptr_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_ADDR_SIZE + 1
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: read pointer, empty flag, fill level and a one-entry
// registered valid/ready output stage in front of the read-domain consumer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_SIZE  = FIFO_ADDR_SIZE
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [ADDR_SIZE:0]    r_wptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_SIZE-1:0]  raddr,
    output logic [ADDR_SIZE:0]    rptr_gray,
    output logic                  rempty,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE:0]    fill_level
);

    localparam int PTR_W = ADDR_SIZE + 1;

    logic [PTR_W-1:0] r_rbin;
    logic [PTR_W-1:0] w_rq2_wptr;
    logic [PTR_W-1:0] w_rbin_next;
    logic [PTR_W-1:0] w_rgray_next;
    logic             w_pop;

    fifo_ptr_sync #(
        .WIDTH (PTR_W)
    ) u_wptr_sync (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .i_d   (r_wptr_gray),
        .o_q   (w_rq2_wptr)
    );

    // Fetch a new word whenever memory has one and the output slot is free
    // or being drained this cycle, giving one word per cycle when streaming.
    assign w_pop        = !rempty && (!out_valid || out_ready);
    assign w_rbin_next  = r_rbin + PTR_W'(w_pop);
    assign w_rgray_next = PTR_W'(bin2gray(FN_W'(w_rbin_next)));

    assign raddr      = r_rbin[ADDR_SIZE-1:0];
    assign fill_level = PTR_W'(gray2bin(FN_W'(w_rq2_wptr)) - FN_W'(r_rbin));

    // Empty is judged against the post-pop pointer, so draining the last
    // word raises rempty on the same edge the pointer moves.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_rbin    <= '0;
            rptr_gray <= '0;
            rempty    <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            r_rbin    <= w_rbin_next;
            rptr_gray <= w_rgray_next;
            rempty    <= (w_rgray_next == w_rq2_wptr);
            if (w_pop) begin
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: the bench plays the write side and the FIFO memory,
// a scoreboard queue holds written words and a monitor checks each handshake.
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int AS    = 3;
    localparam int PW    = AS + 1;
    localparam int DEPTH = 1 << AS;

    logic          r_clk = 1'b0;
    logic          r_rst;
    logic [PW-1:0] r_wptr_gray;
    logic [DW-1:0] mem_rdata;
    logic [AS-1:0] raddr;
    logic [PW-1:0] rptr_gray;
    logic          rempty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] fill_level;

    logic [DW-1:0] tb_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_word;
    logic [PW-1:0] wbin;
    bit            mon_en;
    bit            rnd_on;
    int            n_cmp = 0;
    int            n_err = 0;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_SIZE(AS)) dut (
        .r_clk       (r_clk),
        .r_rst       (r_rst),
        .r_wptr_gray (r_wptr_gray),
        .mem_rdata   (mem_rdata),
        .raddr       (raddr),
        .rptr_gray   (rptr_gray),
        .rempty      (rempty),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level)
    );

    assign mem_rdata = tb_mem[raddr];

    always #5 r_clk = ~r_clk;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        for (int i = 0; i < PW; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge r_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        r_rst       = 1'b1;
        r_wptr_gray = '0;
        wbin        = '0;
        out_ready   = 1'b0;
        exp_q.delete();
        tick(2);
        r_rst = 1'b0;
    endtask

    // Write one word if the memory has room, as seen through the read pointer.
    task automatic push_word(input logic [DW-1:0] d);
        logic [PW-1:0] occ;
        int w;
        w   = 0;
        occ = wbin - to_bin(rptr_gray);
        while (occ >= PW'(DEPTH) && w < 500) begin
            tick(1);
            w++;
            occ = wbin - to_bin(rptr_gray);
        end
        if (w >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL writer_space: occupancy %0d never dropped below %0d", occ, DEPTH);
        end else begin
            tb_mem[wbin[AS-1:0]] = d;
            exp_q.push_back(d);
            wbin        = wbin + 1'b1;
            r_wptr_gray = to_gray(wbin);
        end
    endtask

    // Scoreboard monitor: a handshake seen here completes at the next rising edge.
    always @(negedge r_clk) begin
        if (mon_en && !r_rst) begin
            chk("fill_range", 32'(fill_level <= PW'(DEPTH)), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h with empty scoreboard", out_data);
                end else begin
                    last_word = exp_q.pop_front();
                    chk("data", out_data, last_word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        mon_en = 0;
        rnd_on = 0;

        // Reset with a non-zero write pointer on the wire
        r_rst       = 1'b1;
        r_wptr_gray = 4'b0101;
        out_ready   = 1'b0;
        wbin        = '0;
        tick(2);
        chk("rst_rempty", rempty, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rptr", rptr_gray, 0);
        r_rst = 1'b0;
        tick(2);
        chk("rst_rempty_hold", rempty, 1);
        tick(1);
        chk("rst_rempty_fall", rempty, 0);
        chk("rst_fill", fill_level, 6);

        // Single word: exact latency
        do_reset();
        tb_mem[0]   = 8'hA5;
        wbin        = 4'd1;
        r_wptr_gray = to_gray(wbin);
        out_ready   = 1'b1;
        tick(2);
        chk("sw_rempty_e2", rempty, 1);
        tick(1);
        chk("sw_rempty_e3", rempty, 0);
        chk("sw_valid_e3", out_valid, 0);
        tick(1);
        chk("sw_valid_e4", out_valid, 1);
        chk("sw_data_e4", out_data, 8'hA5);
        chk("sw_raddr_e4", raddr, 1);
        chk("sw_rptr_e4", rptr_gray, 4'b0001);
        chk("sw_rempty_e4", rempty, 1);
        tick(1);
        chk("sw_valid_e5", out_valid, 0);

        // Backpressure then back-to-back drain
        do_reset();
        tb_mem[0]   = 8'h11;
        tb_mem[1]   = 8'h22;
        tb_mem[2]   = 8'h33;
        wbin        = 4'd3;
        r_wptr_gray = to_gray(wbin);
        tick(7);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'h11);
        chk("bp_raddr", raddr, 1);
        out_ready = 1'b1;
        tick(1);
        chk("bp_data2", out_data, 8'h22);
        tick(1);
        chk("bp_data3", out_data, 8'h33);
        chk("bp_valid3", out_valid, 1);
        tick(1);
        chk("bp_valid_end", out_valid, 0);
        chk("bp_data_hold", out_data, 8'h33);

        // Full memory and wrap of the address
        do_reset();
        mon_en = 1;
        for (int i = 0; i < DEPTH; i++) push_word(DW'(8'h40 + i));
        tick(3);
        chk("wr_fill8", fill_level, 8);
        chk("wr_raddr0", raddr, 0);
        tick(1);
        chk("wr_raddr1", raddr, 1);
        chk("wr_fill7", fill_level, 7);
        out_ready = 1'b1;
        tick(10);
        chk("wr_raddr_wrap", raddr, 0);
        chk("wr_rptr8", rptr_gray, 4'b1100);
        chk("wr_rempty", rempty, 1);
        chk("wr_valid", out_valid, 0);
        chk("wr_drained", exp_q.size(), 0);
        for (int i = 0; i < 4; i++) push_word(DW'(8'hC0 + i));
        tick(8);
        chk("wr_lap2_drained", exp_q.size(), 0);
        chk("wr_lap2_raddr", raddr, 4);
        chk("wr_lap2_rptr", rptr_gray, 4'b1010);

        // Random writes against random backpressure
        rnd_on = 1;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    push_word(DW'($urandom));
                    tick(1);
                    if ($urandom_range(0, 4) == 0) tick($urandom_range(1, 6));
                end
                for (int c = 0; c < 2000 && exp_q.size() != 0; c++) tick(1);
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        chk("rnd_drained", exp_q.size(), 0);
        out_ready = 1'b1;
        tick(3);
        chk("rnd_rempty", rempty, 1);
        chk("rnd_fill0", fill_level, 0);

        // Empty idle: nothing moves
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("idle_raddr", raddr, 32'(wbin[AS-1:0]));
            chk("idle_rptr", rptr_gray, to_gray(wbin));
            chk("idle_data", out_data, last_word);
            chk("idle_valid", out_valid, 0);
        end

        // Reset mid-stream with words pending
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(8'h90 + i));
        tick(5);
        chk("mr_valid_pre", out_valid, 1);
        mon_en      = 0;
        r_rst       = 1'b1;
        r_wptr_gray = '0;
        wbin        = '0;
        exp_q.delete();
        tick(1);
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_raddr", raddr, 0);
        chk("mr_rptr", rptr_gray, 0);
        chk("mr_rempty", rempty, 1);
        chk("mr_fill", fill_level, 0);
        r_rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
